branch_prediction: RTL and testbench
====================================

Name: branch_prediction

Overview:
- Gshare dynamic branch predictor: a pattern history table (PHT) of 2-bit saturating counters, indexed by PC XOR global history register (GHR).
- Serves one combinational prediction lookup per cycle.
- Accepts one resolved-branch update per cycle and keeps branch and mispredict statistics.
- Sits beside the fetch stage; resolved outcomes arrive in program order from execute.

Parameters:
- PC_W, 32, program counter width.
- IDX_W, 6, PHT index width; PHT depth = 2^IDX_W.
- GHR_W, 6, global history length; legal range 1..IDX_W.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- pred_valid  in  1  lookup request
- pred_pc  in  PC_W  PC of branch to predict
- pred_taken  out  1  prediction: 1 = taken; 0 whenever pred_valid = 0
- upd_valid  in  1  resolved-branch update strobe
- upd_pc  in  PC_W  PC of resolved branch
- upd_taken  in  1  actual outcome
- mispredict  out  1  registered one-cycle pulse for a mispredicted update
- ghr  out  GHR_W  current global history
- branch_count  out  32  number of updates since reset
- mispredict_count  out  32  number of mispredicted updates since reset

Behaviour:
- Index = pc[IDX_W+1:2] XOR zero-extended ghr. PC bits [1:0] are ignored.
- Counter encoding: 00 strong-not-taken, 01 weak-not-taken, 10 weak-taken, 11 strong-taken. Predicted direction = counter MSB.
- Prediction is combinational, zero latency: pred_taken = pred_valid & PHT[index(pred_pc)][1].
- On a clock edge with upd_valid = 1, using the pre-edge ghr for the index:
  - Counter increments if upd_taken = 1, saturating at 11.
  - Counter decrements if upd_taken = 0, saturating at 00.
  - A mispredict is counter MSB != upd_taken, evaluated on the pre-update counter.
  - mispredict register <= that result; otherwise mispredict <= 0.
  - branch_count += 1; mispredict_count += 1 on a mispredict. Both wrap modulo 2^32.
  - ghr <= {ghr[GHR_W-2:0], upd_taken}; newest outcome goes in the LSB.
- With upd_valid = 0: PHT, ghr and counts hold; mispredict = 0.
- Simultaneous predict and update in the same cycle: the prediction uses pre-edge PHT and ghr, even when both access the same entry.
- GHR is non-speculative; it changes only on updates.
- Reset (rst = 1 at a rising edge, including mid-operation):
  - All PHT entries <= 01.
  - ghr <= 0; branch_count <= 0; mispredict_count <= 0; mispredict <= 0.
  - An update presented in the reset cycle is ignored.
  - Reset takes priority over everything.
  - pred_taken stays combinational and reads 0 after reset.

Decomposition:
- Package bp_pkg holds:
  - typedef cnt_t (2-bit counter).
  - Constants CNT_SNT = 0, CNT_WNT = 1, CNT_WT = 2, CNT_ST = 3, CNT_INIT = CNT_WNT.
  - Function sat_update(cnt_t, taken) returning cnt_t.
- One natural sub-module, bp_pht: the PHT register array with one combinational read port, one registered update port, and reset-to-CNT_INIT.
- Index hashing, GHR and statistics stay in branch_prediction.

Test Plan:
- Cold predict: after reset, pred_valid = 1, pred_pc = 0x100 -> pred_taken = 0; ghr = 0; both counts = 0.
- Training an always-taken branch: 8 consecutive updates pc = 0x100, taken = 1.
  - Updates 1..7 mispredict; update 8 is correct (index 63 counter 01 -> 10 -> 11).
  - Result: branch_count = 8, mispredict_count = 7, ghr = 0x3F.
  - Then predict pc = 0x100 -> pred_taken = 1.
- Low saturation: after reset, 3 updates pc = 0x0, taken = 0.
  - Index stays 0; counter 01 -> 00 -> 00 -> 00.
  - mispredict never asserts; branch_count = 3, mispredict_count = 0, ghr = 0.
- Same-cycle hazard: after reset, pred_pc = 0x0 and upd_pc = 0x0 with taken = 1 in the same cycle.
  - pred_taken = 0 in that cycle.
  - Next cycle: mispredict = 1, ghr = 1, PHT[0] = 10.
- High saturation: drive ghr to 0x3F, then 10 taken updates at pc = 0x100 -> PHT[63] saturates at 11. One not-taken update then:
  - Counts a mispredict and leaves PHT[63] = 10.
  - Sets ghr = 0x3E.
  - mispredict pulses for exactly one cycle.
- Reset mid-run: after the training scenario, assert rst for 1 cycle together with an upd_valid.
  - Counts = 0, ghr = 0; the update is ignored.
  - Predict pc = 0x100 -> pred_taken = 0.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types, counter encodings and the saturating-counter helper for
// the gshare branch predictor.
package bp_pkg;

  // 2-bit saturating direction counter; MSB is the predicted direction.
  typedef logic [1:0] cnt_t;

  localparam cnt_t CNT_SNT  = 2'd0;
  localparam cnt_t CNT_WNT  = 2'd1;
  localparam cnt_t CNT_WT   = 2'd2;
  localparam cnt_t CNT_ST   = 2'd3;
  localparam cnt_t CNT_INIT = CNT_WNT;

  // Move a counter one step toward the actual outcome, clamping at the ends.
  function automatic cnt_t sat_update(input cnt_t cnt, input logic taken);
    cnt_t next_cnt;
    if (taken) begin
      if (cnt == CNT_ST) begin
        next_cnt = CNT_ST;
      end else begin
        next_cnt = cnt + 2'd1;
      end
    end else begin
      if (cnt == CNT_SNT) begin
        next_cnt = CNT_SNT;
      end else begin
        next_cnt = cnt - 2'd1;
      end
    end
    return next_cnt;
  endfunction

endpackage

// File: rtl/bp_pht.sv
// Pattern history table: array of 2-bit counters with one combinational
// lookup port and one update port. The update port also exposes the
// pre-update counter so the caller can judge the prediction it replaced.
module bp_pht
  import bp_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] i_rd_idx,
  output cnt_t             o_rd_cnt,
  input  logic             i_upd_valid,
  input  logic [IDX_W-1:0] i_upd_idx,
  input  logic             i_upd_taken,
  output cnt_t             o_upd_cnt
);

  localparam int DEPTH = 1 << IDX_W;

  cnt_t r_pht [DEPTH];

  // Both reads see the pre-edge contents, so a same-cycle lookup and
  // update of one entry return the old counter.
  assign o_rd_cnt  = r_pht[i_rd_idx];
  assign o_upd_cnt = r_pht[i_upd_idx];

  // Counter storage: reset every entry to weak-not-taken, else train one entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pht[i] <= CNT_INIT;
      end
    end else if (i_upd_valid) begin
      r_pht[i_upd_idx] <= sat_update(r_pht[i_upd_idx], i_upd_taken);
    end
  end

endmodule

// File: rtl/branch_prediction.sv
// Gshare branch predictor top: hashes PC with the global history to index
// the PHT, keeps the non-speculative history and branch statistics.
// GHR_W is expected to lie in 1..IDX_W.
module branch_prediction
  import bp_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int IDX_W = 6,
  parameter int GHR_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pred_valid,
  input  logic [PC_W-1:0]  pred_pc,
  output logic             pred_taken,
  input  logic             upd_valid,
  input  logic [PC_W-1:0]  upd_pc,
  input  logic             upd_taken,
  output logic             mispredict,
  output logic [GHR_W-1:0] ghr,
  output logic [31:0]      branch_count,
  output logic [31:0]      mispredict_count
);

  logic [GHR_W-1:0] r_ghr;
  logic [31:0]      r_branch_count;
  logic [31:0]      r_mispredict_count;
  logic             r_mispredict;

  logic [IDX_W-1:0] w_ghr_ext;
  logic [IDX_W-1:0] w_pred_idx;
  logic [IDX_W-1:0] w_upd_idx;
  logic [GHR_W-1:0] w_ghr_next;
  cnt_t             w_rd_cnt;
  cnt_t             w_upd_cnt;
  logic             w_mispredict;
  logic             w_unused_pc_bits;

  // Word-aligned PC bits XOR zero-extended history; byte offset is ignored.
  assign w_ghr_ext  = IDX_W'(r_ghr);
  assign w_pred_idx = pred_pc[IDX_W+1:2] ^ w_ghr_ext;
  assign w_upd_idx  = upd_pc[IDX_W+1:2] ^ w_ghr_ext;

  // Shift the newest outcome into the LSB; the cast drops the oldest bit
  // and stays legal even for a 1-bit history.
  assign w_ghr_next = GHR_W'({r_ghr, upd_taken});

  // Judged against the counter as it stood before this update.
  assign w_mispredict = (w_upd_cnt[1] != upd_taken);

  // PC bits outside the index field do not take part in the hash.
  assign w_unused_pc_bits = ^{pred_pc[PC_W-1:IDX_W+2], pred_pc[1:0],
                              upd_pc[PC_W-1:IDX_W+2],  upd_pc[1:0]};

  bp_pht #(
    .IDX_W (IDX_W)
  ) u_pht (
    .clk         (clk),
    .rst         (rst),
    .i_rd_idx    (w_pred_idx),
    .o_rd_cnt    (w_rd_cnt),
    .i_upd_valid (upd_valid),
    .i_upd_idx   (w_upd_idx),
    .i_upd_taken (upd_taken),
    .o_upd_cnt   (w_upd_cnt)
  );

  // Zero-latency prediction, forced low when no lookup is requested.
  always_comb begin
    pred_taken = 1'b0;
    if (pred_valid) begin
      pred_taken = w_rd_cnt[1];
    end else begin
      pred_taken = 1'b0;
    end
  end

  // History, statistics and the mispredict pulse advance only on updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ghr              <= '0;
      r_branch_count     <= 32'd0;
      r_mispredict_count <= 32'd0;
      r_mispredict       <= 1'b0;
    end else if (upd_valid) begin
      r_ghr          <= w_ghr_next;
      r_branch_count <= r_branch_count + 32'd1;
      if (w_mispredict) begin
        r_mispredict_count <= r_mispredict_count + 32'd1;
      end
      r_mispredict   <= w_mispredict;
    end else begin
      r_mispredict   <= 1'b0;
    end
  end

  assign ghr              = r_ghr;
  assign branch_count     = r_branch_count;
  assign mispredict_count = r_mispredict_count;
  assign mispredict       = r_mispredict;

endmodule

// File: tb/tb_branch_prediction.sv
// Self-checking bench for the gshare predictor: directed scenarios followed
// by random traffic, all checked against an array-based reference model.
module tb_branch_prediction;

  logic        clk;
  logic        rst;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        mispredict;
  logic [5:0]  ghr;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: counter values 0..3, history as an integer.
  int          m_pht [64];
  int          m_ghr;
  int unsigned m_bc;
  int unsigned m_mc;
  int          m_misp;

  branch_prediction #(
    .PC_W  (32),
    .IDX_W (6),
    .GHR_W (6)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .pred_valid       (pred_valid),
    .pred_pc          (pred_pc),
    .pred_taken       (pred_taken),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .mispredict       (mispredict),
    .ghr              (ghr),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_value(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int m_index(input logic [31:0] pc);
    return ((pc / 4) % 64) ^ m_ghr;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 64; i++) m_pht[i] = 1;
    m_ghr  = 0;
    m_bc   = 0;
    m_mc   = 0;
    m_misp = 0;
  endfunction

  function automatic void m_update(input logic [31:0] pc, input logic taken);
    int idx;
    int predicted;
    idx       = m_index(pc);
    predicted = (m_pht[idx] >= 2) ? 1 : 0;
    m_misp    = (predicted != int'(taken)) ? 1 : 0;
    m_bc      = m_bc + 1;
    m_mc      = m_mc + m_misp;
    if (taken) m_pht[idx] = (m_pht[idx] < 3) ? m_pht[idx] + 1 : 3;
    else       m_pht[idx] = (m_pht[idx] > 0) ? m_pht[idx] - 1 : 0;
    m_ghr     = ((m_ghr * 2) + int'(taken)) % 64;
  endfunction

  // One clock: present inputs, check the combinational prediction mid-cycle,
  // then check the registered state just after the edge.
  task automatic step(input logic pv, input logic [31:0] ppc, input logic uv,
                      input logic [31:0] upc, input logic ut, input logic rs);
    int exp_pred;
    pred_valid = pv;
    pred_pc    = ppc;
    upd_valid  = uv;
    upd_pc     = upc;
    upd_taken  = ut;
    rst        = rs;
    exp_pred   = (pv && (m_pht[m_index(ppc)] >= 2)) ? 1 : 0;
    #4;
    check_value("pred_taken", {31'd0, pred_taken}, exp_pred);
    @(posedge clk);
    if (rs) m_reset();
    else if (uv) m_update(upc, ut);
    else m_misp = 0;
    #1;
    check_value("mispredict", {31'd0, mispredict}, m_misp);
    check_value("ghr", {26'd0, ghr}, m_ghr);
    check_value("branch_count", branch_count, m_bc);
    check_value("mispredict_count", mispredict_count, m_mc);
  endtask

  task automatic do_reset(input logic uv);
    step(1'b0, 32'd0, uv, 32'h100, 1'b1, 1'b1);
  endtask

  initial begin
    logic [31:0] pcs [8];
    pcs[0] = 32'h100; pcs[1] = 32'h0;   pcs[2] = 32'h4;   pcs[3] = 32'h8;
    pcs[4] = 32'h104; pcs[5] = 32'h1FC; pcs[6] = 32'h203; pcs[7] = 32'hFFFF_FF00;
    m_reset();
    rst = 1'b1; pred_valid = 1'b0; pred_pc = 32'd0;
    upd_valid = 1'b0; upd_pc = 32'd0; upd_taken = 1'b0;
    @(posedge clk);
    #1;
    do_reset(1'b0);

    // Cold predict.
    step(1'b1, 32'h100, 1'b0, 32'd0, 1'b0, 1'b0);
    check_value("cold_ghr", {26'd0, ghr}, 32'd0);

    // Training an always-taken branch.
    for (int i = 0; i < 8; i++) step(1'b0, 32'd0, 1'b1, 32'h100, 1'b1, 1'b0);
    check_value("train_bc", branch_count, 32'd8);
    check_value("train_mc", mispredict_count, 32'd7);
    check_value("train_ghr", {26'd0, ghr}, 32'h3F);
    step(1'b1, 32'h100, 1'b0, 32'd0, 1'b0, 1'b0);

    // Reset mid-run with a concurrent update that must be ignored.
    do_reset(1'b1);
    check_value("rst_bc", branch_count, 32'd0);
    step(1'b1, 32'h100, 1'b0, 32'd0, 1'b0, 1'b0);

    // Low saturation.
    for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b1, 32'h0, 1'b0, 1'b0);
    check_value("low_mc", mispredict_count, 32'd0);
    check_value("low_bc", branch_count, 32'd3);

    // Same-cycle hazard on entry 0, then look at entry 0 again (pc 4 ^ ghr 1).
    do_reset(1'b0);
    step(1'b1, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0);
    check_value("hazard_misp", {31'd0, mispredict}, 32'd1);
    check_value("hazard_ghr", {26'd0, ghr}, 32'd1);
    step(1'b1, 32'h4, 1'b0, 32'd0, 1'b0, 1'b0);

    // High saturation then one not-taken update.
    do_reset(1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 32'd0, 1'b1, 32'h40, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 32'd0, 1'b1, 32'h100, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 32'h100, 1'b0, 1'b0);
    check_value("sat_misp", {31'd0, mispredict}, 32'd1);
    check_value("sat_ghr", {26'd0, ghr}, 32'h3E);
    step(1'b1, 32'h4, 1'b0, 32'd0, 1'b0, 1'b0);
    check_value("sat_pulse", {31'd0, mispredict}, 32'd0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ppc;
      logic [31:0] upc;
      ppc = ($urandom_range(0, 3) == 0) ? $urandom : pcs[$urandom_range(0, 7)];
      upc = ($urandom_range(0, 3) == 0) ? $urandom : pcs[$urandom_range(0, 7)];
      step(1'($urandom_range(0, 1)), ppc, 1'($urandom_range(0, 3) != 0), upc,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 49) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
